// File: rtl/llc_req_queue.sv
// Request queue between the trace reader and the LLC: FWFT buffer with illegal-op filtering.
// Optional pop statistics (rd/wr/snoop counters) are enabled by defining LLC_REQ_STATS_EN.
module llc_req_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_WIDTH-1:0]          in_op,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  output logic                         out_valid,
  output logic [OP_WIDTH-1:0]          out_op,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  input  logic                         hold,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         illegal_op,
  output logic [15:0]                  illegal_cnt
`ifdef LLC_REQ_STATS_EN
  ,
  output logic [31:0]                  rd_cnt,
  output logic [31:0]                  wr_cnt,
  output logic [31:0]                  snoop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = OP_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, PRESENT, STALLED} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            illegal_op_reg;
  logic [15:0]     illegal_cnt_reg;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic            op_legal, push, push_legal, push_illegal, pop;

  assign op_legal     = (in_op != OP_WIDTH'(7)) && (in_op < OP_WIDTH'(10));
  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign in_ready     = !full && !rst;
  assign push         = in_valid && in_ready;
  assign push_legal   = push && op_legal;
  assign push_illegal = push && !op_legal;

  // The FSM state alone decides whether a head is presented; it tracks !empty exactly.
  assign out_valid = (state_reg != IDLE);
  assign pop       = out_valid && !hold;
  assign head      = mem[rd_ptr_reg];
  assign out_op    = out_valid ? head[EW-1:ADDR_WIDTH] : {OP_WIDTH{1'b1}};
  assign out_addr  = out_valid ? head[ADDR_WIDTH-1:0] : '0;

  assign count       = count_reg;
  assign illegal_op  = illegal_op_reg;
  assign illegal_cnt = illegal_cnt_reg;

  always_comb begin
    count_next = count_reg;
    if (push_legal && !pop)
      count_next = count_reg + CW'(1);
    else if (!push_legal && pop)
      count_next = count_reg - CW'(1);

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_next != '0) state_next = PRESENT;
      PRESENT: begin
        if (pop && count_next == '0) state_next = IDLE;
        else if (hold)               state_next = STALLED;
        else                         state_next = PRESENT;
      end
      STALLED: if (!hold) state_next = (count_next == '0) ? IDLE : PRESENT;
      default: state_next = IDLE;
    endcase
  end

  // Storage is left unreset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_legal)
      mem[wr_ptr_reg] <= {in_op, in_addr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      illegal_op_reg  <= 1'b0;
      illegal_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      illegal_op_reg <= push_illegal;
      if (push_legal) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push_illegal && illegal_cnt_reg != 16'hFFFF)
        illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
    end
  end

`ifdef LLC_REQ_STATS_EN
  logic [31:0] rd_cnt_reg, wr_cnt_reg, snoop_cnt_reg;

  assign rd_cnt    = rd_cnt_reg;
  assign wr_cnt    = wr_cnt_reg;
  assign snoop_cnt = snoop_cnt_reg;

  // A popped clear (op 8) wipes the statistics, mirroring the LLC's own reset-on-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_reg    <= '0;
      wr_cnt_reg    <= '0;
      snoop_cnt_reg <= '0;
    end else if (pop) begin
      if (out_op == OP_WIDTH'(8)) begin
        rd_cnt_reg    <= '0;
        wr_cnt_reg    <= '0;
        snoop_cnt_reg <= '0;
      end else if (out_op == OP_WIDTH'(0) || out_op == OP_WIDTH'(2)) begin
        rd_cnt_reg <= rd_cnt_reg + 32'd1;
      end else if (out_op == OP_WIDTH'(1)) begin
        wr_cnt_reg <= wr_cnt_reg + 32'd1;
      end else if (out_op >= OP_WIDTH'(3) && out_op <= OP_WIDTH'(6)) begin
        snoop_cnt_reg <= snoop_cnt_reg + 32'd1;
      end
    end
  end
`endif

endmodule
